// File: rtl/bsg_link_pkg.sv
// rtl/bsg_link_pkg.sv - shared link geometry for both ends of the off-chip link
// Purpose: single source for beat layout and credit size so that the upstream
//   transmitter and this receiver agree on beat order and token batching.
// Ports: none (package).
package bsg_link_pkg;

  localparam int CHANNELS    = 2;
  localparam int CH_WIDTH    = 8;
  localparam int WORD_WIDTH  = 64;
  localparam int FIFO_DEPTH  = 16;
  localparam int TOKEN_BATCH = 8;

  localparam int BEAT_WIDTH     = CHANNELS * CH_WIDTH;
  localparam int BEATS_PER_WORD = WORD_WIDTH / BEAT_WIDTH;

  // One beat across all channels, channel 0 in the low bits.
  typedef logic [BEAT_WIDTH-1:0] beat_t;

endpackage

// File: rtl/bsg_downstream_rx_if.sv
// rtl/bsg_downstream_rx_if.sv - pin-side and core-side signals of the link receiver
// Purpose: bundles the beat input, credit return and core valid/yumi handshake.
// Ports (slave = receiver view):
//   io_valid_in, io_data_in_ch0/ch1 : beats from the pins
//   io_token_out                     : credit pulse back to the transmitter
//   core_valid_out, core_data_out    : FIFO head towards the core
//   core_yumi_in                     : core consumes the head
interface bsg_downstream_rx_if #(
  parameter int CH_WIDTH   = bsg_link_pkg::CH_WIDTH,
  parameter int WORD_WIDTH = bsg_link_pkg::WORD_WIDTH
);

  logic                  io_valid_in;
  logic [CH_WIDTH-1:0]   io_data_in_ch0;
  logic [CH_WIDTH-1:0]   io_data_in_ch1;
  logic                  io_token_out;
  logic                  core_valid_out;
  logic [WORD_WIDTH-1:0] core_data_out;
  logic                  core_yumi_in;

  modport slave (
    input  io_valid_in, io_data_in_ch0, io_data_in_ch1, core_yumi_in,
    output io_token_out, core_valid_out, core_data_out
  );

  modport master (
    output io_valid_in, io_data_in_ch0, io_data_in_ch1, core_yumi_in,
    input  io_token_out, core_valid_out, core_data_out
  );

endinterface

// File: rtl/bsg_downstream_fifo.sv
// rtl/bsg_downstream_fifo.sv - first-word-fall-through receive buffer
// Purpose: DEPTH-entry FWFT FIFO; a push into a full FIFO is accepted when a
//   pop happens in the same cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push_i, data_i    : write request and word
//   full_o            : no free entry (before any same-cycle pop)
//   pop_i             : consume head; ignored while valid_o=0
//   data_o, valid_o   : head word and its valid
module bsg_downstream_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Extra MSB on each pointer tells full from empty when the indices match.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;

  logic empty;
  logic pop_ok;
  logic push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i & ~empty;
  assign push_ok = push_i & (~full_o | pop_ok);

  assign valid_o = ~empty;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
  end

  // Storage is cleared on reset so the head word reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
    end
  end

endmodule

// File: rtl/bsg_downstream_rx.sv
// rtl/bsg_downstream_rx.sv - receive end of the source-synchronous link
// Purpose: assembles pin beats into core words, buffers them in a FWFT FIFO,
//   returns one credit token per TOKEN_BATCH consumed words and flags drops.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   link         : bsg_downstream_rx_if slave (pins + core handshake)
//   overflow_err : sticky, a completed word was dropped on a full FIFO
module bsg_downstream_rx #(
  parameter int CHANNELS    = bsg_link_pkg::CHANNELS,
  parameter int CH_WIDTH    = bsg_link_pkg::CH_WIDTH,
  parameter int WORD_WIDTH  = bsg_link_pkg::WORD_WIDTH,
  parameter int FIFO_DEPTH  = bsg_link_pkg::FIFO_DEPTH,
  parameter int TOKEN_BATCH = bsg_link_pkg::TOKEN_BATCH
) (
  input  logic                  clk,
  input  logic                  rst,
  bsg_downstream_rx_if.slave    link,
  output logic                  overflow_err
);

  localparam int BW    = CHANNELS * CH_WIDTH;
  localparam int BEATS = WORD_WIDTH / BW;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TCW   = $clog2(TOKEN_BATCH);

  logic [BCW-1:0]             beat_cnt_q, beat_cnt_d;
  logic [BEATS-1:0][BW-1:0]   asm_q, asm_d;
  logic [TCW-1:0]             cons_cnt_q, cons_cnt_d;
  logic                       token_q, token_d;
  logic                       ovf_q, ovf_d;

  logic [BW-1:0]              beat_in;
  logic                       last_beat;
  logic                       pop_fire;
  logic                       fifo_full;
  logic [WORD_WIDTH-1:0]      push_word;

  assign beat_in   = {link.io_data_in_ch1, link.io_data_in_ch0};
  assign last_beat = link.io_valid_in && (beat_cnt_q == BCW'(BEATS - 1));
  assign pop_fire  = link.core_yumi_in && link.core_valid_out;

  always_comb begin
    asm_d      = asm_q;
    beat_cnt_d = beat_cnt_q;
    if (link.io_valid_in) begin
      asm_d[beat_cnt_q] = beat_in;
      beat_cnt_d        = last_beat ? '0 : beat_cnt_q + 1'b1;
    end
    // Taking the word from asm_d bypasses the last beat straight into the push.
    push_word  = asm_d;
    cons_cnt_d = cons_cnt_q + TCW'(pop_fire);
    token_d    = pop_fire && (cons_cnt_q == TCW'(TOKEN_BATCH - 1));
    ovf_d      = ovf_q | (last_beat & fifo_full & ~pop_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      asm_q      <= '0;
      cons_cnt_q <= '0;
      token_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      asm_q      <= asm_d;
      cons_cnt_q <= cons_cnt_d;
      token_q    <= token_d;
      ovf_q      <= ovf_d;
    end
  end

  bsg_downstream_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (last_beat),
    .data_i  (push_word),
    .full_o  (fifo_full),
    .pop_i   (link.core_yumi_in),
    .data_o  (link.core_data_out),
    .valid_o (link.core_valid_out)
  );

  assign link.io_token_out = token_q;
  assign overflow_err      = ovf_q;

endmodule

// File: tb/tb_bsg_downstream_rx.sv
// tb/tb_bsg_downstream_rx.sv - self-checking bench for bsg_downstream_rx
module tb_bsg_downstream_rx;
  import bsg_link_pkg::*;

  localparam int WW = WORD_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ovf;

  bsg_downstream_rx_if bus ();

  bsg_downstream_rx #(
    .CHANNELS    (CHANNELS),
    .CH_WIDTH    (CH_WIDTH),
    .WORD_WIDTH  (WORD_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TOKEN_BATCH (TOKEN_BATCH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .link         (bus),
    .overflow_err (ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int tok_seen = 0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] make_word(input int i);
    logic [WW-1:0] w;
    w = '0;
    for (int b = 0; b < WW / 8; b++) w[8*b +: 8] = 8'(i * 8 + b);
    return w;
  endfunction

  // Reference model: beats collected in a list, words kept in a queue.
  beat_t         m_pend[$];
  logic [WW-1:0] m_fifo[$];
  int            m_pops;
  bit            m_ovf, m_tok, m_popped;
  int            m_pre;
  logic [WW-1:0] m_w;

  always @(posedge clk) begin
    if (rst) begin
      m_pend.delete();
      m_fifo.delete();
      m_pops = 0;
      m_ovf  = 0;
      m_tok  = 0;
    end else begin
      m_pre    = m_fifo.size();
      m_popped = bus.core_yumi_in && (m_pre > 0);
      if (m_popped) begin
        void'(m_fifo.pop_front());
        m_pops++;
      end
      m_tok = m_popped && (m_pops % TOKEN_BATCH == 0);
      if (bus.io_valid_in) begin
        m_pend.push_back({bus.io_data_in_ch1, bus.io_data_in_ch0});
        if (m_pend.size() == BEATS_PER_WORD) begin
          m_w = '0;
          for (int k = 0; k < BEATS_PER_WORD; k++)
            m_w = m_w | (WW'(m_pend[k]) << (BEAT_WIDTH * k));
          m_pend.delete();
          if (m_pre < FIFO_DEPTH || m_popped) m_fifo.push_back(m_w);
          else m_ovf = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_valid", WW'(bus.core_valid_out), WW'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) check("model_data", bus.core_data_out, m_fifo[0]);
    check("model_token", WW'(bus.io_token_out), WW'(m_tok));
    check("model_ovf", WW'(ovf), WW'(m_ovf));
    if (bus.io_token_out === 1'b1) tok_seen++;
  end

  task automatic send_beats(input logic [WW-1:0] w, input int n, input int gap, input bit yumi_last);
    for (int k = 0; k < n; k++) begin
      bus.io_valid_in    = 1'b1;
      bus.io_data_in_ch0 = w[BEAT_WIDTH*k +: CH_WIDTH];
      bus.io_data_in_ch1 = w[BEAT_WIDTH*k + CH_WIDTH +: CH_WIDTH];
      if (yumi_last && k == n - 1) bus.core_yumi_in = 1'b1;
      @(negedge clk);
      bus.io_valid_in = 1'b0;
      if (yumi_last && k == n - 1) bus.core_yumi_in = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int gap);
    send_beats(w, BEATS_PER_WORD, gap, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pop_all_check(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.core_yumi_in = 1'b1;
      check("pop_valid", WW'(bus.core_valid_out), WW'(1));
      check("pop_data", bus.core_data_out, make_word(base + i));
      @(negedge clk);
    end
    bus.core_yumi_in = 1'b0;
    check("drained_valid", WW'(bus.core_valid_out), WW'(0));
  endtask

  initial begin
    bus.io_valid_in    = 1'b0;
    bus.io_data_in_ch0 = '0;
    bus.io_data_in_ch1 = '0;
    bus.core_yumi_in   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", WW'(bus.core_valid_out), WW'(0));
    check("rst_data", bus.core_data_out, WW'(0));
    check("rst_token", WW'(bus.io_token_out), WW'(0));
    check("rst_ovf", WW'(ovf), WW'(0));
    rst = 1'b0;

    // Single word on consecutive cycles.
    send_word(make_word(0), 0);
    check("single_valid", WW'(bus.core_valid_out), WW'(1));
    check("single_data", bus.core_data_out, 64'h0706050403020100);
    bus.core_yumi_in = 1'b1;
    @(negedge clk);
    bus.core_yumi_in = 1'b0;

    // Same word with two idle cycles between beats.
    send_word(make_word(0), 2);
    check("gap_valid", WW'(bus.core_valid_out), WW'(1));
    check("gap_data", bus.core_data_out, 64'h0706050403020100);
    bus.core_yumi_in = 1'b1;
    @(negedge clk);
    bus.core_yumi_in = 1'b0;

    // Token batching: 8 words -> 1 pulse, 16 words -> 2 pulses.
    do_reset();
    tok_seen = 0;
    bus.core_yumi_in = 1'b1;
    for (int i = 0; i < 8; i++) send_word(make_word(i), 0);
    repeat (4) @(negedge clk);
    check("tokens_8", WW'(tok_seen), WW'(1));
    do_reset();
    tok_seen = 0;
    for (int i = 0; i < 16; i++) send_word(make_word(i), 0);
    repeat (4) @(negedge clk);
    check("tokens_16", WW'(tok_seen), WW'(2));
    bus.core_yumi_in = 1'b0;

    // Overflow: 16 fill the FIFO, the 17th is dropped.
    do_reset();
    for (int i = 0; i < 16; i++) send_word(make_word(i), 0);
    check("full_no_ovf", WW'(ovf), WW'(0));
    send_word(make_word(16), 0);
    check("ovf_set", WW'(ovf), WW'(1));
    pop_all_check(0, 16);
    check("ovf_sticky", WW'(ovf), WW'(1));

    // Full with a pop on the same edge as the 17th word's last beat.
    do_reset();
    for (int i = 0; i < 16; i++) send_word(make_word(i), 0);
    send_beats(make_word(16), BEATS_PER_WORD, 0, 1'b1);
    check("fullpop_no_ovf", WW'(ovf), WW'(0));
    pop_all_check(1, 16);

    // Reset mid-word clears the partial word, FIFO and consume counter.
    do_reset();
    bus.core_yumi_in = 1'b1;
    for (int i = 0; i < 3; i++) send_word(make_word(i), 0);
    repeat (2) @(negedge clk);
    bus.core_yumi_in = 1'b0;
    send_word(make_word(20), 0);
    send_beats(make_word(21), 2, 0, 1'b0);
    do_reset();
    tok_seen = 0;
    check("rstmid_empty", WW'(bus.core_valid_out), WW'(0));
    send_word(make_word(30), 0);
    check("rstmid_valid", WW'(bus.core_valid_out), WW'(1));
    check("rstmid_data", bus.core_data_out, make_word(30));
    bus.core_yumi_in = 1'b1;
    @(negedge clk);
    bus.core_yumi_in = 1'b0;
    check("rstmid_single", WW'(bus.core_valid_out), WW'(0));
    bus.core_yumi_in = 1'b1;
    for (int i = 0; i < 4; i++) send_word(make_word(40 + i), 0);
    repeat (4) @(negedge clk);
    check("rstmid_tok_5", WW'(tok_seen), WW'(0));
    for (int i = 0; i < 3; i++) send_word(make_word(50 + i), 0);
    repeat (4) @(negedge clk);
    check("rstmid_tok_8", WW'(tok_seen), WW'(1));
    bus.core_yumi_in = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
